// File: rtl/pedc_routine_sequencer.sv
// pedc_routine_sequencer
//   Issuing side of the PE dataflow controller Start/Stop handshake. Accepts a
//   convolution job, pulses Start_Routine, walks every KERNEL x KERNEL window
//   position, drains the PE pipeline, pulses Stop_Routine and reports Done.
//
// Ports
//   PEDC_SEQUENCER_Clk / _Reset_InLow      clock, async active-low reset
//   PEDC_SEQUENCER_Job_Valid/_Ready        job handshake, dims sampled at accept
//   PEDC_SEQUENCER_Job_Rows/_Cols          feature-map dimensions
//   PEDC_SEQUENCER_Pe_Stall                hold current window
//   PEDC_SEQUENCER_Abort                   terminate running job
//   PEDC_SEQUENCER_Start/Stop_Routine      1-cycle pulses to the PEDC
//   PEDC_SEQUENCER_Window_Valid            Row/Col_Index is a live window
//   PEDC_SEQUENCER_Row/Col_Index           top-left corner of current window
//   PEDC_SEQUENCER_Busy                    not idle
//   PEDC_SEQUENCER_Done                    1-cycle pulse at job end
//   PEDC_SEQUENCER_Aborted                 level, last job ended by Abort
//   PEDC_SEQUENCER_Dim_Error               1-cycle pulse, job rejected
module pedc_routine_sequencer #(
    parameter int DIM_W        = 8,
    parameter int KERNEL       = 3,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             PEDC_SEQUENCER_Clk,
    input  logic             PEDC_SEQUENCER_Reset_InLow,
    input  logic             PEDC_SEQUENCER_Job_Valid,
    output logic             PEDC_SEQUENCER_Job_Ready,
    input  logic [DIM_W-1:0] PEDC_SEQUENCER_Job_Rows,
    input  logic [DIM_W-1:0] PEDC_SEQUENCER_Job_Cols,
    input  logic             PEDC_SEQUENCER_Pe_Stall,
    input  logic             PEDC_SEQUENCER_Abort,
    output logic             PEDC_SEQUENCER_Start_Routine,
    output logic             PEDC_SEQUENCER_Stop_Routine,
    output logic             PEDC_SEQUENCER_Window_Valid,
    output logic [DIM_W-1:0] PEDC_SEQUENCER_Row_Index,
    output logic [DIM_W-1:0] PEDC_SEQUENCER_Col_Index,
    output logic             PEDC_SEQUENCER_Busy,
    output logic             PEDC_SEQUENCER_Done,
    output logic             PEDC_SEQUENCER_Aborted,
    output logic             PEDC_SEQUENCER_Dim_Error
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DIM_W-1:0] K_DIM    = DIM_W'(KERNEL);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] rows_q, rows_d;
    logic [DIM_W-1:0] cols_q, cols_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic             aborted_q, aborted_d;
    logic             dim_err_q, dim_err_d;

    logic             accept;
    logic             dims_ok;
    logic             last_col;
    logic             last_row;
    logic             abortable;

    assign accept    = (state_q == S_IDLE) && PEDC_SEQUENCER_Job_Valid;
    assign dims_ok   = (PEDC_SEQUENCER_Job_Rows >= K_DIM) && (PEDC_SEQUENCER_Job_Cols >= K_DIM);
    assign last_col  = (col_q == (cols_q - K_DIM));
    assign last_row  = (row_q == (rows_q - K_DIM));
    assign abortable = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);

    // State register
    always_ff @(posedge PEDC_SEQUENCER_Clk or negedge PEDC_SEQUENCER_Reset_InLow) begin
        if (!PEDC_SEQUENCER_Reset_InLow) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Abort outranks both stall and the last-window advance
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && dims_ok) state_d = S_START;
            end
            S_START: begin
                state_d = PEDC_SEQUENCER_Abort ? S_STOP : S_RUN;
            end
            S_RUN: begin
                if (PEDC_SEQUENCER_Abort)
                    state_d = S_STOP;
                else if (!PEDC_SEQUENCER_Pe_Stall && last_col && last_row)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (PEDC_SEQUENCER_Abort || (drain_q == DRN_LAST)) state_d = S_STOP;
            end
            S_STOP:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        rows_d    = rows_q;
        cols_d    = cols_q;
        row_d     = row_q;
        col_d     = col_q;
        drain_d   = drain_q;
        aborted_d = aborted_q;
        dim_err_d = 1'b0;

        if (accept) begin
            rows_d    = PEDC_SEQUENCER_Job_Rows;
            cols_d    = PEDC_SEQUENCER_Job_Cols;
            row_d     = '0;
            col_d     = '0;
            aborted_d = 1'b0;
            dim_err_d = !dims_ok;
        end

        if (abortable && PEDC_SEQUENCER_Abort) begin
            aborted_d = 1'b1;
        end else if (state_q == S_RUN && !PEDC_SEQUENCER_Pe_Stall) begin
            if (!last_col) begin
                col_d = col_q + 1'b1;
            end else if (!last_row) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end
            drain_d = '0;
        end else if (state_q == S_DRAIN) begin
            drain_d = drain_q + 1'b1;
        end
    end

    always_ff @(posedge PEDC_SEQUENCER_Clk or negedge PEDC_SEQUENCER_Reset_InLow) begin
        if (!PEDC_SEQUENCER_Reset_InLow) begin
            rows_q    <= '0;
            cols_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            drain_q   <= '0;
            aborted_q <= 1'b0;
            dim_err_q <= 1'b0;
        end else begin
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            row_q     <= row_d;
            col_q     <= col_d;
            drain_q   <= drain_d;
            aborted_q <= aborted_d;
            dim_err_q <= dim_err_d;
        end
    end

    // Output decode from registered state; Window_Valid also masks on Pe_Stall
    always_comb begin
        PEDC_SEQUENCER_Job_Ready     = (state_q == S_IDLE);
        PEDC_SEQUENCER_Start_Routine = (state_q == S_START);
        PEDC_SEQUENCER_Stop_Routine  = (state_q == S_STOP);
        PEDC_SEQUENCER_Done          = (state_q == S_DONE);
        PEDC_SEQUENCER_Busy          = (state_q != S_IDLE);
        PEDC_SEQUENCER_Window_Valid  = (state_q == S_RUN) && !PEDC_SEQUENCER_Pe_Stall;
        PEDC_SEQUENCER_Row_Index     = row_q;
        PEDC_SEQUENCER_Col_Index     = col_q;
        PEDC_SEQUENCER_Aborted       = aborted_q;
        PEDC_SEQUENCER_Dim_Error     = dim_err_q;
    end

endmodule

// File: tb/tb_pedc_routine_sequencer.sv
// tb_pedc_routine_sequencer
//   Directed per-cycle vectors: each record holds the inputs for one cycle and
//   the outputs expected during that cycle. Phase letters name the expected
//   controller phase: I idle, S start, W window, H held window, D drain,
//   P stop pulse, F done pulse.
module tb_pedc_routine_sequencer;

    logic       clk;
    logic       rst_n;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_rows;
    logic [7:0] job_cols;
    logic       pe_stall;
    logic       abort_in;
    logic       start_r;
    logic       stop_r;
    logic       win_valid;
    logic [7:0] row_idx;
    logic [7:0] col_idx;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       dim_err;

    pedc_routine_sequencer #(
        .DIM_W       (8),
        .KERNEL      (3),
        .DRAIN_CYCLES(2)
    ) dut (
        .PEDC_SEQUENCER_Clk          (clk),
        .PEDC_SEQUENCER_Reset_InLow  (rst_n),
        .PEDC_SEQUENCER_Job_Valid    (job_valid),
        .PEDC_SEQUENCER_Job_Ready    (job_ready),
        .PEDC_SEQUENCER_Job_Rows     (job_rows),
        .PEDC_SEQUENCER_Job_Cols     (job_cols),
        .PEDC_SEQUENCER_Pe_Stall     (pe_stall),
        .PEDC_SEQUENCER_Abort        (abort_in),
        .PEDC_SEQUENCER_Start_Routine(start_r),
        .PEDC_SEQUENCER_Stop_Routine (stop_r),
        .PEDC_SEQUENCER_Window_Valid (win_valid),
        .PEDC_SEQUENCER_Row_Index    (row_idx),
        .PEDC_SEQUENCER_Col_Index    (col_idx),
        .PEDC_SEQUENCER_Busy         (busy),
        .PEDC_SEQUENCER_Done         (done),
        .PEDC_SEQUENCER_Aborted      (aborted),
        .PEDC_SEQUENCER_Dim_Error    (dim_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] r;
        logic [7:0] c;
        logic       st;
        logic       ab;
        byte        ph;
        logic [7:0] er;
        logic [7:0] ec;
        logic       eab;
        logic       ede;
    } tv_t;

    tv_t tq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic add(input logic v, input int r, input int c, input logic st,
                       input logic ab, input byte ph, input int er, input int ec,
                       input logic eab, input logic ede);
        tv_t t;
        t.v = v; t.r = 8'(r); t.c = 8'(c); t.st = st; t.ab = ab; t.ph = ph;
        t.er = 8'(er); t.ec = 8'(ec); t.eab = eab; t.ede = ede;
        tq.push_back(t);
    endtask

    task automatic drive(input tv_t t);
        job_valid = t.v;
        job_rows  = t.r;
        job_cols  = t.c;
        pe_stall  = t.st;
        abort_in  = t.ab;
    endtask

    // Bundle order: ready start stop wv busy done aborted dim_err
    task automatic compare(input tv_t t, input string tag, input int idx);
        logic [7:0] exp_b;
        logic [7:0] act_b;
        logic       bad;
        case (t.ph)
            "I":     exp_b = 8'b1000_0000;
            "S":     exp_b = 8'b0100_1000;
            "W":     exp_b = 8'b0001_1000;
            "P":     exp_b = 8'b0010_1000;
            "F":     exp_b = 8'b0000_1100;
            default: exp_b = 8'b0000_1000;
        endcase
        exp_b[1] = t.eab;
        exp_b[0] = t.ede;
        act_b = {job_ready, start_r, stop_r, win_valid, busy, done, aborted, dim_err};
        bad = (act_b !== exp_b);
        if (t.ph == "W" && (row_idx !== t.er || col_idx !== t.ec)) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s[%0d] phase=%c outputs got=%b want=%b row got=%0d want=%0d col got=%0d want=%0d",
                     tag, idx, t.ph, act_b, exp_b, row_idx, t.er, col_idx, t.ec);
        end
    endtask

    task automatic step(input tv_t t, input string tag, input int idx);
        @(negedge clk);
        drive(t);
        #1;
        compare(t, tag, idx);
    endtask

    initial begin
        tv_t t;
        rst_n = 1'b0;
        job_valid = 1'b0; job_rows = '0; job_cols = '0; pe_stall = 1'b0; abort_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        t.v = 0; t.r = 0; t.c = 0; t.st = 0; t.ab = 0; t.ph = "I";
        t.er = 0; t.ec = 0; t.eab = 0; t.ede = 0;
        compare(t, "reset", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4x4 no stall; abort ignored in DONE and IDLE
        add(1,4,4,0,0,"I",0,0,0,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,0,0,"W",0,0,0,0);
        add(0,0,0,0,0,"W",0,1,0,0);
        add(0,0,0,0,0,"W",1,0,0,0);
        add(0,0,0,0,0,"W",1,1,0,0);
        add(0,0,0,0,0,"D",0,0,0,0);
        add(0,0,0,0,0,"D",0,0,0,0);
        add(0,0,0,0,0,"P",0,0,0,0);
        add(0,0,0,0,1,"F",0,0,0,0);
        add(0,0,0,0,1,"I",0,0,0,0);
        // 4x4 with stall on cycles 3-4; stall ignored in DRAIN
        add(1,4,4,0,0,"I",0,0,0,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,0,0,"W",0,0,0,0);
        add(0,0,0,1,0,"H",0,0,0,0);
        add(0,0,0,1,0,"H",0,0,0,0);
        add(0,0,0,0,0,"W",0,1,0,0);
        add(0,0,0,0,0,"W",1,0,0,0);
        add(0,0,0,0,0,"W",1,1,0,0);
        add(0,0,0,1,0,"D",0,0,0,0);
        add(0,0,0,1,0,"D",0,0,0,0);
        add(0,0,0,0,0,"P",0,0,0,0);
        add(0,0,0,0,0,"F",0,0,0,0);
        // 8x8 aborted on cycle 4
        add(1,8,8,0,0,"I",0,0,0,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,0,0,"W",0,0,0,0);
        add(0,0,0,0,0,"W",0,1,0,0);
        add(0,0,0,0,1,"W",0,2,0,0);
        add(0,0,0,0,0,"P",0,0,1,0);
        add(0,0,0,0,0,"F",0,0,1,0);
        add(0,0,0,0,0,"I",0,0,1,0);
        // 3x3 single window, aborted on it
        add(1,3,3,0,0,"I",0,0,1,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,0,1,"W",0,0,0,0);
        add(0,0,0,0,0,"P",0,0,1,0);
        add(0,0,0,0,0,"F",0,0,1,0);
        // Rejected dims; reject also clears Aborted
        add(1,2,5,0,0,"I",0,0,1,0);
        add(0,0,0,0,0,"I",0,0,0,1);
        add(1,5,2,0,0,"I",0,0,0,0);
        add(0,0,0,0,0,"I",0,0,0,1);
        add(0,0,0,0,0,"I",0,0,0,0);
        // 4x5 non-square
        add(1,4,5,0,0,"I",0,0,0,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,0,0,"W",0,0,0,0);
        add(0,0,0,0,0,"W",0,1,0,0);
        add(0,0,0,0,0,"W",0,2,0,0);
        add(0,0,0,0,0,"W",1,0,0,0);
        add(0,0,0,0,0,"W",1,1,0,0);
        add(0,0,0,0,0,"W",1,2,0,0);
        add(0,0,0,0,0,"D",0,0,0,0);
        add(0,0,0,0,0,"D",0,0,0,0);
        add(0,0,0,0,0,"P",0,0,0,0);
        add(0,0,0,0,0,"F",0,0,0,0);
        // Abort in START
        add(1,5,5,0,0,"I",0,0,0,0);
        add(0,0,0,0,1,"S",0,0,0,0);
        add(0,0,0,0,0,"P",0,0,1,0);
        add(0,0,0,0,0,"F",0,0,1,0);
        // Abort together with stall
        add(1,5,5,0,0,"I",0,0,1,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,1,1,"H",0,0,0,0);
        add(0,0,0,0,0,"P",0,0,1,0);
        add(0,0,0,0,0,"F",0,0,1,0);
        // Abort in DRAIN
        add(1,3,3,0,0,"I",0,0,1,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,0,0,"W",0,0,0,0);
        add(0,0,0,0,1,"D",0,0,0,0);
        add(0,0,0,0,0,"P",0,0,1,0);
        add(0,0,0,0,0,"F",0,0,1,0);
        add(0,0,0,0,0,"I",0,0,1,0);

        foreach (tq[i]) step(tq[i], "vec", i);

        // Asynchronous reset in the middle of RUN
        tq.delete();
        add(1,8,8,0,0,"I",0,0,1,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,0,0,"W",0,0,0,0);
        add(0,0,0,0,0,"W",0,1,0,0);
        foreach (tq[i]) step(tq[i], "pre_rst", i);
        #2;
        rst_n = 1'b0;
        #1;
        t.v = 0; t.r = 0; t.c = 0; t.st = 0; t.ab = 0; t.ph = "I";
        t.er = 0; t.ec = 0; t.eab = 0; t.ede = 0;
        compare(t, "async_rst", 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            compare(t, "in_rst", i);
        end
        @(negedge clk);
        rst_n = 1'b1;

        tq.delete();
        add(0,0,0,0,0,"I",0,0,0,0);
        add(1,3,3,0,0,"I",0,0,0,0);
        add(0,0,0,0,0,"S",0,0,0,0);
        add(0,0,0,0,0,"W",0,0,0,0);
        add(0,0,0,0,0,"D",0,0,0,0);
        add(0,0,0,0,0,"D",0,0,0,0);
        add(0,0,0,0,0,"P",0,0,0,0);
        add(0,0,0,0,0,"F",0,0,0,0);
        add(0,0,0,0,0,"I",0,0,0,0);
        foreach (tq[i]) step(tq[i], "post_rst", i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
